// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation classes, funct codes and decoded operation kinds
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_FUNCT = 2'b10, OP_OR = 2'b11;
  localparam logic [5:0] F_SLL = 6'b000000, F_ADD = 6'b100000, F_ADDU = 6'b100001,
    F_SUB = 6'b100010, F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101,
    F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLT = 6'b101010, F_SLTU = 6'b101011;
  typedef enum logic [3:0] {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU, K_SLL, K_NONE} kind_t;
endpackage

// File: rtl/add32_cin.sv
// add32_cin: adder with carry-in, carry-out and signed overflow
module add32_cin #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_whole.sv
// alu_whole: registered ALU with operand mux, funct decode and branch target adder
module alu_whole
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clkd,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] a_dat,
  input  logic [WIDTH-1:0] b_dat,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carryout,
  output logic             overflow,
  output logic [WIDTH-1:0] branch_target
);
  kind_t kind;
  logic [WIDTH-1:0] opb, add_b, sum, bt_sum, res_c;
  logic sub, arith, cout, ovf, unused_bt_cout, unused_bt_ovf;
  assign opb = alu_src ? imm : b_dat;
  always_comb begin
    kind = K_NONE;
    case (alu_op)
      OP_ADD: kind = K_ADD;
      OP_SUB: kind = K_SUB;
      OP_OR: kind = K_OR;
      default:
        case (funct)
          F_ADD, F_ADDU: kind = K_ADD;
          F_SUB, F_SUBU: kind = K_SUB;
          F_AND: kind = K_AND;
          F_OR: kind = K_OR;
          F_XOR: kind = K_XOR;
          F_NOR: kind = K_NOR;
          F_SLT: kind = K_SLT;
          F_SLTU: kind = K_SLTU;
          F_SLL: kind = K_SLL;
          default: kind = K_NONE;
        endcase
    endcase
  end
  // set-less-than compares reuse the subtracting adder
  assign sub = kind inside {K_SUB, K_SLT, K_SLTU};
  assign arith = kind inside {K_ADD, K_SUB};
  assign add_b = sub ? ~opb : opb;
  add32_cin #(.WIDTH(WIDTH)) u_alu_add (
    .a(a_dat), .b(add_b), .cin(sub), .sum(sum), .cout(cout), .ovf(ovf)
  );
  add32_cin #(.WIDTH(WIDTH)) u_bt_add (
    .a(pc_plus4), .b(imm), .cin(1'b0), .sum(bt_sum), .cout(unused_bt_cout), .ovf(unused_bt_ovf)
  );
  always_comb begin
    res_c = '0;
    case (kind)
      K_ADD, K_SUB: res_c = sum;
      K_AND: res_c = a_dat & opb;
      K_OR: res_c = a_dat | opb;
      K_XOR: res_c = a_dat ^ opb;
      K_NOR: res_c = ~(a_dat | opb);
      K_SLT: res_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      K_SLTU: res_c = {{(WIDTH-1){1'b0}}, ~cout};
      K_SLL: res_c = opb << a_dat[4:0];
      default: res_c = '0;
    endcase
  end
  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero <= 1'b0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      branch_target <= '0;
    end else begin
      result <= res_c;
      zero <= res_c == '0;
      carryout <= arith & cout;
      overflow <= arith & ovf;
      branch_target <= bt_sum;
    end
  end
endmodule

// File: tb/tb_alu_whole.sv
// tb_alu_whole: directed and random checks of alu_whole against an arithmetic reference model
module tb_alu_whole;
  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    logic [31:0] bt;
  } exp_t;
  logic clkd = 1'b0;
  logic rst = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic alu_src = 1'b0;
  logic [31:0] pc_plus4 = 32'h0, a_dat = 32'h0, b_dat = 32'h0, imm = 32'h0;
  logic [31:0] result, branch_target;
  logic zero, carryout, overflow;
  int errors = 0;
  int checks = 0;
  alu_whole #(.WIDTH(32)) dut (
    .clkd(clkd), .rst(rst), .alu_op(alu_op), .funct(funct), .alu_src(alu_src),
    .pc_plus4(pc_plus4), .a_dat(a_dat), .b_dat(b_dat), .imm(imm),
    .result(result), .zero(zero), .carryout(carryout), .overflow(overflow),
    .branch_target(branch_target)
  );
  always #5 clkd = ~clkd;
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic src,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] pc);
    exp_t e;
    logic [31:0] bb;
    longint u, s;
    int k;
    e = '0;
    bb = src ? im : b;
    k = (op == 2'b00) ? 32 : (op == 2'b01) ? 34 : (op == 2'b11) ? 37 : int'(f);
    case (k)
      32, 33: begin
        u = longint'(a) + longint'(bb);
        s = longint'($signed(a)) + longint'($signed(bb));
        e.r = u[31:0];
        e.c = u[32];
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      34, 35: begin
        u = longint'(a) - longint'(bb);
        s = longint'($signed(a)) - longint'($signed(bb));
        e.r = u[31:0];
        e.c = a >= bb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      36: e.r = a & bb;
      37: e.r = a | bb;
      38: e.r = a ^ bb;
      39: e.r = ~(a | bb);
      42: e.r = {31'b0, $signed(a) < $signed(bb)};
      43: e.r = {31'b0, a < bb};
      0: e.r = bb << a[4:0];
      default: e.r = 32'h0;
    endcase
    e.z = e.r == 32'h0;
    e.bt = pc + im;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".result"}, result, e.r);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e.z});
    chk({tag, ".carryout"}, {31'b0, carryout}, {31'b0, e.c});
    chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, e.v});
    chk({tag, ".branch_target"}, branch_target, e.bt);
  endtask
  task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] f, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] pc);
    exp_t e;
    alu_op = op;
    funct = f;
    alu_src = src;
    a_dat = a;
    b_dat = b;
    imm = im;
    pc_plus4 = pc;
    e = model(op, f, src, a, b, im, pc);
    @(posedge clkd);
    #1;
    chk_all(tag, e);
  endtask
  initial begin
    exp_t e;
    logic [5:0] codes [11];
    logic [5:0] f;
    codes = '{6'h00, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    alu_op = 2'b00;
    alu_src = 1'b0;
    a_dat = 32'h1234;
    b_dat = 32'h1;
    pc_plus4 = 32'h100;
    imm = 32'h8;
    #1 rst = 1'b1;
    #1;
    chk_all("reset_async", '0);
    @(posedge clkd);
    #1;
    chk_all("reset_over_edge", '0);
    rst = 1'b0;
    apply("add_imm", 2'b00, 6'h00, 1'b1, 32'h10, 32'h99, 32'h4, 32'h0);
    chk("add_imm.value", result, 32'h14);
    apply("sub_equal", 2'b01, 6'h00, 1'b0, 32'h5, 32'h5, 32'h0, 32'h0);
    chk("sub_equal.zero", {31'b0, zero}, 32'h1);
    apply("sub_borrow", 2'b01, 6'h00, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0);
    apply("add_ovf", 2'b10, 6'h20, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("add_ovf.value", result, 32'h80000000);
    apply("add_carry", 2'b10, 6'h21, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    apply("slt", 2'b10, 6'h2A, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("slt.value", result, 32'h1);
    apply("sltu", 2'b10, 6'h2B, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("sltu.value", result, 32'h0);
    apply("slt_minint", 2'b10, 6'h2A, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0);
    apply("sll", 2'b10, 6'h00, 1'b0, 32'h00000024, 32'h0000000B, 32'h0, 32'h0);
    chk("sll.value", result, 32'h00000B0);
    apply("bad_funct", 2'b10, 6'h02, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    apply("or_class", 2'b11, 6'h20, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 32'h0);
    apply("nor", 2'b10, 6'h27, 1'b1, 32'h0000_00FF, 32'h0, 32'hFF00_0000, 32'h0);
    apply("branch", 2'b00, 6'h00, 1'b0, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h00400004);
    chk("branch.value", branch_target, 32'h00400000);
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 10)] : 6'($urandom);
      apply("random", 2'($urandom), f, 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    end
    apply("pre_reset", 2'b00, 6'h00, 1'b0, 32'h11, 32'h22, 32'h30, 32'h40);
    alu_op = 2'b01;
    a_dat = 32'h9;
    b_dat = 32'h3;
    #2 rst = 1'b1;
    #1;
    chk_all("reset_mid", '0);
    #2 rst = 1'b0;
    e = model(2'b01, 6'h00, 1'b0, 32'h9, 32'h3, imm, pc_plus4);
    #1;
    chk_all("reset_hold", '0);
    @(posedge clkd);
    #1;
    chk_all("post_reset", e);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end
endmodule

// File: doc/alu_whole.md
ALU_WHOLE -- requirements
Module: alu_whole

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, datapath width; all behaviour below is specified at 32.
REQ-002 The block SHALL have the following port: clkd, in, 1, the single clock, rising-edge active.
REQ-003 The block SHALL have the following port: rst, in, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have the following port: alu_op, in, 2, ALU operation class.
REQ-005 The block SHALL have the following port: funct, in, 6, R-type function field.
REQ-006 The block SHALL have the following port: alu_src, in, 1, B-operand select; 0 selects b_dat, 1 selects imm.
REQ-007 The block SHALL have the following ports, each in, 32: pc_plus4, a_dat, b_dat, imm (imm is already sign-extended).
REQ-008 The block SHALL have the following port: result, out, 32, registered ALU result.
REQ-009 The block SHALL have the following ports, each out, 1, registered flags: zero, carryout, overflow.
REQ-010 The block SHALL have the following port: branch_target, out, 32, registered pc_plus4 + imm.

Function
REQ-011 Operand B SHALL be alu_src ? imm : b_dat; the selection is combinational.
REQ-012 The operation SHALL be decoded from alu_op as follows: 00 = ADD, 01 = SUB, 11 = OR, 10 = decode from funct.
REQ-013 For alu_op 10, funct SHALL decode as: 100000/100001 = ADD, 100010/100011 = SUB, 100100 = AND, 100101 = OR, 100110 = XOR, 100111 = NOR, 101010 = SLT (signed), 101011 = SLTU, and 000000 = SLL (B shifted left by A[4:0]).
REQ-014 Any other funct value SHALL produce result 0, carryout 0 and overflow 0.
REQ-015 ADD SHALL compute A+B+0 and SUB SHALL compute A+~B+1, both on one shared 32-bit adder with carry-in; results wrap modulo 2^32.
REQ-016 For ADD and SUB, carryout SHALL be the adder carry out of bit 31; for SUB, carryout 1 means no unsigned borrow.
REQ-017 For ADD and SUB, overflow SHALL be 1 when the two adder inputs have equal sign bits and the sum sign differs from them.
REQ-018 carryout and overflow SHALL be 0 for all operations other than ADD and SUB.
REQ-019 SLT SHALL return 1 when A < B signed, computed as sum[31] XOR adder_overflow of A−B; SLTU SHALL return 1 when the A−B adder carry out is 0; all other result bits SHALL be 0.
REQ-020 zero SHALL be 1 when the 32-bit combinational result equals 0, and SHALL be registered in the same cycle as result.
REQ-021 branch_target SHALL be computed by a second, independent adder as pc_plus4 + imm, carry-in 0, wrapping modulo 2^32, with its carry discarded.
REQ-022 All outputs SHALL update on the rising edge of clkd, one cycle of latency; there is no handshake and no enable, so a new operation is accepted every cycle.
REQ-023 Inputs that change between edges SHALL affect only the next registered value; outputs SHALL be glitch-free between edges.

Reset
REQ-024 While rst = 1, result, zero, carryout, overflow and branch_target SHALL all be 0 immediately, independent of clkd.
REQ-025 After rst deasserts, the first rising edge of clkd SHALL capture the current inputs normally.
REQ-026 If rst asserts mid-operation, the operation in flight SHALL be discarded.
REQ-027 If rst and a clkd edge occur together, reset SHALL win.

Structure
REQ-028 The alu_op encodings and funct codes SHALL be defined as named constants in a shared package, alu_pkg.
REQ-029 A sub-module add32_cin SHALL be used, with ports a, b, cin, sum, cout, ovf; it SHALL be instantiated twice, once for the ALU add/sub and once for branch_target.
REQ-030 The operand mux and the decode logic SHALL stay inline in alu_whole.

Verification
REQ-031 Scenario: alu_op 00, alu_src 1, a_dat 0x10, imm 0x4 -> next edge result 0x14, zero 0, carryout 0, overflow 0.
REQ-032 Scenario: alu_op 01, a_dat 0x5, b_dat 0x5 -> result 0, zero 1, carryout 1.
REQ-033 Scenario: alu_op 10, funct 100000, a_dat 0x7FFFFFFF, b_dat 0x1 -> result 0x80000000, overflow 1, carryout 0.
REQ-034 Scenario: funct 101010, a_dat 0xFFFFFFFF, b_dat 0x1 -> result 1; the same operands with funct 101011 -> result 0.
REQ-035 Scenario: pc_plus4 0x00400004, imm 0xFFFFFFFC -> branch_target 0x00400000.
REQ-036 Scenario: drive nonzero outputs, then assert rst between clock edges -> all outputs 0 immediately; release rst -> the next edge captures the current inputs.
